gtech_latch_wr_ctrl: RTL and testbench

//  Synchronous write-side controller for a bank of NENT active-low-gated, active-low-cleared GTECH latches.

---
 rtl/gtech_latch_pkg.sv | 26 ++
 rtl/gtech_latch_wr_ctrl_if.sv | 48 ++++
 rtl/gtech_latch_phase_cnt.sv | 26 ++
 rtl/gtech_latch_wr_ctrl.sv | 127 ++++++++++++
 tb/tb_gtech_latch_wr_ctrl.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/gtech_latch_pkg.sv
// Shared definitions for the GTECH latch write controller: FSM state codes,
// latch control reset levels and the phase-counter width helper.
package gtech_latch_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_SETUP = 3'd1;
  localparam state_t ST_OPEN  = 3'd2;
  localparam state_t ST_HOLD  = 3'd3;
  localparam state_t ST_CLEAR = 3'd4;

  localparam logic GATE_CLOSED  = 1'b1;
  localparam logic CLEAR_ACTIVE = 1'b0;

  // The counter holds 0..max-1, so it needs clog2(max) bits but never fewer than one.
  function automatic int phase_cnt_width(input int setup_cyc, input int open_cyc,
                                         input int hold_cyc);
    int m;
    m = setup_cyc;
    if (open_cyc > m) m = open_cyc;
    if (hold_cyc > m) m = hold_cyc;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/gtech_latch_wr_ctrl_if.sv
// Request and latch-bank bus of the GTECH latch write controller.
// GTECH_LATCH_WR_SHADOW_EN adds the RD_ADDR/RD_DATA shadow read port.
interface gtech_latch_wr_ctrl_if #(
  parameter int DW   = 8,
  parameter int NENT = 4,
  parameter int AW   = 2
);
  import gtech_latch_pkg::*;

  // Handshake: a write is taken on a rising CP edge when REQ_VALID and REQ_READY
  // are both high and CLR_REQ is low; CLR_REQ in IDLE wins and the request waits.
  // REQ_VALID must stay high with stable REQ_ADDR/REQ_DATA until it is taken.
  logic            REQ_VALID;
  logic            REQ_READY;
  logic [AW-1:0]   REQ_ADDR;
  logic [DW-1:0]   REQ_DATA;
  logic            CLR_REQ;
  logic [DW-1:0]   LD_D;
  logic [NENT-1:0] LD_GN;
  logic [NENT-1:0] LD_CD;
  logic            BUSY;
  logic            DONE;
  logic            ADDR_ERR;
  state_t          dbg_state;
`ifdef GTECH_LATCH_WR_SHADOW_EN
  logic [AW-1:0]   RD_ADDR;
  logic [DW-1:0]   RD_DATA;

  modport slave (
    input  REQ_VALID, REQ_ADDR, REQ_DATA, CLR_REQ, RD_ADDR,
    output REQ_READY, LD_D, LD_GN, LD_CD, BUSY, DONE, ADDR_ERR, dbg_state, RD_DATA
  );
  modport master (
    output REQ_VALID, REQ_ADDR, REQ_DATA, CLR_REQ, RD_ADDR,
    input  REQ_READY, LD_D, LD_GN, LD_CD, BUSY, DONE, ADDR_ERR, dbg_state, RD_DATA
  );
`else
  modport slave (
    input  REQ_VALID, REQ_ADDR, REQ_DATA, CLR_REQ,
    output REQ_READY, LD_D, LD_GN, LD_CD, BUSY, DONE, ADDR_ERR, dbg_state
  );
  modport master (
    output REQ_VALID, REQ_ADDR, REQ_DATA, CLR_REQ,
    input  REQ_READY, LD_D, LD_GN, LD_CD, BUSY, DONE, ADDR_ERR, dbg_state
  );
`endif

endinterface

// File: rtl/gtech_latch_phase_cnt.sv
// Loadable down-counter that times every controller phase; tc flags the last cycle.
module gtech_latch_phase_cnt #(
  parameter int CW = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          tc
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/gtech_latch_wr_ctrl.sv
// Write/clear sequencer for a bank of active-low GTECH latches; all outputs registered.
// GTECH_LATCH_WR_SHADOW_EN adds a shadow copy of the latch contents readable via RD_ADDR.
module gtech_latch_wr_ctrl
  import gtech_latch_pkg::*;
#(
  parameter int DW        = 8,
  parameter int NENT      = 4,
  parameter int AW        = 2,
  parameter int SETUP_CYC = 1,
  parameter int OPEN_CYC  = 1,
  parameter int HOLD_CYC  = 1
) (
  input logic                 CP,
  input logic                 CD,
  gtech_latch_wr_ctrl_if.slave bus
);

  localparam int CW = phase_cnt_width(SETUP_CYC, OPEN_CYC, HOLD_CYC);

  state_t          state;
  state_t          state_nxt;
  logic [AW-1:0]   addr_q;
  logic            accept;
  logic            in_range;
  logic            tc;
  logic            load;
  logic [CW-1:0]   load_val;
  logic [NENT-1:0] gn_nxt;

  assign accept   = (state == ST_IDLE) && !bus.CLR_REQ && bus.REQ_VALID && bus.REQ_READY;
  assign in_range = 32'(addr_q) < 32'(NENT);
  assign bus.dbg_state = state;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (bus.CLR_REQ) state_nxt = ST_CLEAR;
                else if (accept) state_nxt = ST_SETUP;
      ST_SETUP: if (tc) state_nxt = ST_OPEN;
      ST_OPEN:  if (tc) state_nxt = ST_HOLD;
      ST_HOLD:  if (tc) state_nxt = ST_IDLE;
      ST_CLEAR: if (tc) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Reload the shared counter on every state change with that phase's length minus one.
  assign load = (state_nxt != state);

  always_comb begin
    load_val = '0;
    case (state_nxt)
      ST_SETUP: load_val = CW'(SETUP_CYC - 1);
      ST_OPEN:  load_val = CW'(OPEN_CYC - 1);
      ST_HOLD:  load_val = CW'(HOLD_CYC - 1);
      ST_CLEAR: load_val = CW'(OPEN_CYC - 1);
      default:  load_val = '0;
    endcase
  end

  gtech_latch_phase_cnt #(.CW(CW)) u_phase_cnt (
    .clk      (CP),
    .rst_n    (CD),
    .load     (load),
    .load_val (load_val),
    .tc       (tc)
  );

  // Gates are decoded from the next state and registered so only one bit ever toggles.
  always_comb begin
    gn_nxt = {NENT{GATE_CLOSED}};
    for (int i = 0; i < NENT; i++) begin
      if ((state_nxt == ST_OPEN) && in_range && (32'(addr_q) == i)) gn_nxt[i] = !GATE_CLOSED;
    end
  end

  always_ff @(posedge CP or negedge CD) begin
    if (!CD) begin
      state         <= ST_IDLE;
      addr_q        <= '0;
      bus.LD_D      <= '0;
      bus.LD_GN     <= {NENT{GATE_CLOSED}};
      bus.LD_CD     <= {NENT{CLEAR_ACTIVE}};
      bus.REQ_READY <= 1'b0;
      bus.BUSY      <= 1'b0;
      bus.DONE      <= 1'b0;
      bus.ADDR_ERR  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        addr_q   <= bus.REQ_ADDR;
        bus.LD_D <= bus.REQ_DATA;
      end
      bus.LD_GN     <= gn_nxt;
      bus.LD_CD     <= (state_nxt == ST_CLEAR) ? {NENT{CLEAR_ACTIVE}} : {NENT{!CLEAR_ACTIVE}};
      bus.REQ_READY <= (state_nxt == ST_IDLE);
      bus.BUSY      <= (state_nxt != ST_IDLE);
      bus.DONE      <= (state != ST_IDLE) && (state_nxt == ST_IDLE);
      bus.ADDR_ERR  <= (state == ST_HOLD) && (state_nxt == ST_IDLE) && !in_range;
    end
  end

`ifdef GTECH_LATCH_WR_SHADOW_EN
  logic [DW-1:0] shadow [NENT];

  // Mirror the latch: capture on HOLD entry (gate just closed), wipe on CLEAR entry.
  always_ff @(posedge CP or negedge CD) begin
    if (!CD) begin
      for (int i = 0; i < NENT; i++) shadow[i] <= '0;
    end else if ((state_nxt == ST_CLEAR) && (state != ST_CLEAR)) begin
      for (int i = 0; i < NENT; i++) shadow[i] <= '0;
    end else if ((state == ST_OPEN) && (state_nxt == ST_HOLD)) begin
      for (int i = 0; i < NENT; i++) begin
        if (32'(addr_q) == i) shadow[i] <= bus.LD_D;
      end
    end
  end

  always_comb begin
    bus.RD_DATA = '0;
    for (int i = 0; i < NENT; i++) begin
      if (32'(bus.RD_ADDR) == i) bus.RD_DATA = shadow[i];
    end
  end
`endif

endmodule

// File: tb/tb_gtech_latch_wr_ctrl.sv
// Bench for gtech_latch_wr_ctrl: directed scenarios then random traffic, checked
// each cycle against a timeline model of write/clear sequences.
module tb_gtech_latch_wr_ctrl;
  import gtech_latch_pkg::*;

  localparam int DW = 8;
  localparam int NENT = 3;
  localparam int AW = 2;
  localparam int SETUP_CYC = 2;
  localparam int OPEN_CYC = 3;
  localparam int HOLD_CYC = 1;
  localparam int OP_NONE = 0;
  localparam int OP_WR = 1;
  localparam int OP_CLR = 2;

  logic CP = 1'b0;
  logic CD = 1'b1;
  always #5 CP = ~CP;

  gtech_latch_wr_ctrl_if #(.DW(DW), .NENT(NENT), .AW(AW)) bus ();

  gtech_latch_wr_ctrl #(
    .DW(DW), .NENT(NENT), .AW(AW),
    .SETUP_CYC(SETUP_CYC), .OPEN_CYC(OPEN_CYC), .HOLD_CYC(HOLD_CYC)
  ) u_dut (
    .CP  (CP),
    .CD  (CD),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;

  // Reference model: the current operation and the cycle it was taken in.
  int            op_kind = OP_NONE;
  int            op_t0 = 0;
  int            op_addr = 0;
  logic [DW-1:0] op_data = '0;
  logic [DW-1:0] ld_d_exp = '0;
  logic          acc = 1'b0;
`ifdef GTECH_LATCH_WR_SHADOW_EN
  logic [DW-1:0] shadow_m [NENT];
  logic [AW-1:0] rd_addr_drv = '0;
`endif

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, act, exp, cyc);
  endtask

  task automatic model_reset();
    op_kind  = OP_NONE;
    ld_d_exp = '0;
    acc      = 1'b0;
`ifdef GTECH_LATCH_WR_SHADOW_EN
    for (int i = 0; i < NENT; i++) shadow_m[i] = '0;
`endif
  endtask

  function automatic int op_len();
    return (op_kind == OP_WR) ? SETUP_CYC + OPEN_CYC + HOLD_CYC : OPEN_CYC;
  endfunction

  task automatic check_reset(input string tag);
    check({tag, "_ld_gn"}, 32'(bus.LD_GN), 32'({NENT{1'b1}}));
    check({tag, "_ld_cd"}, 32'(bus.LD_CD), 32'(0));
    check({tag, "_ld_d"}, 32'(bus.LD_D), 32'(0));
    check({tag, "_ready"}, 32'(bus.REQ_READY), 32'(0));
    check({tag, "_busy"}, 32'(bus.BUSY), 32'(0));
    check({tag, "_done"}, 32'(bus.DONE), 32'(0));
    check({tag, "_addr_err"}, 32'(bus.ADDR_ERR), 32'(0));
  endtask

  // Expected outputs from the position within the current operation's timeline.
  task automatic check_cycle();
    int off;
    logic [NENT-1:0] gn_e, cd_e;
    logic busy_e, done_e, err_e;
    gn_e = '1; cd_e = '1; busy_e = 1'b0; done_e = 1'b0; err_e = 1'b0;
    off = cyc - op_t0;
    if (op_kind != OP_NONE && off <= op_len()) begin
      busy_e = 1'b1;
      if (op_kind == OP_CLR) cd_e = '0;
      else if (off > SETUP_CYC && off <= SETUP_CYC + OPEN_CYC && op_addr < NENT)
        gn_e = ~(NENT'(1) << op_addr);
    end else if (op_kind != OP_NONE && off == op_len() + 1) begin
      done_e = 1'b1;
      err_e  = (op_kind == OP_WR) && (op_addr >= NENT);
    end
    check("ld_gn", 32'(bus.LD_GN), 32'(gn_e));
    check("ld_cd", 32'(bus.LD_CD), 32'(cd_e));
    check("ld_d", 32'(bus.LD_D), 32'(ld_d_exp));
    check("busy", 32'(bus.BUSY), 32'(busy_e));
    check("req_ready", 32'(bus.REQ_READY), 32'(!busy_e));
    check("done", 32'(bus.DONE), 32'(done_e));
    check("addr_err", 32'(bus.ADDR_ERR), 32'(err_e));
`ifdef GTECH_LATCH_WR_SHADOW_EN
    check("rd_data", 32'(bus.RD_DATA),
          32'((32'(bus.RD_ADDR) < NENT) ? shadow_m[bus.RD_ADDR] : '0));
`endif
  endtask

  // What the coming clock edge does, decided from this cycle's inputs.
  task automatic advance();
    int off;
    acc = 1'b0;
    off = cyc - op_t0;
`ifdef GTECH_LATCH_WR_SHADOW_EN
    if (op_kind == OP_WR && off == SETUP_CYC + OPEN_CYC && op_addr < NENT)
      shadow_m[op_addr] = op_data;
`endif
    if (op_kind == OP_NONE || off > op_len()) begin
      if (bus.CLR_REQ) begin
        op_kind = OP_CLR;
        op_t0   = cyc;
`ifdef GTECH_LATCH_WR_SHADOW_EN
        for (int i = 0; i < NENT; i++) shadow_m[i] = '0;
`endif
      end else if (bus.REQ_VALID) begin
        op_kind  = OP_WR;
        op_t0    = cyc;
        op_addr  = int'(bus.REQ_ADDR);
        op_data  = bus.REQ_DATA;
        ld_d_exp = bus.REQ_DATA;
        acc      = 1'b1;
      end
    end
  endtask

  // Called just after a rising edge; drives one cycle, checks it, steps the model.
  task automatic tick(input logic v, input int a, input int d, input logic c);
    bus.REQ_VALID = v;
    bus.REQ_ADDR  = AW'(a);
    bus.REQ_DATA  = DW'(d);
    bus.CLR_REQ   = c;
`ifdef GTECH_LATCH_WR_SHADOW_EN
    bus.RD_ADDR   = rd_addr_drv;
`endif
    @(negedge CP);
    check_cycle();
    advance();
    @(posedge CP);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, $urandom_range(0, 3), $urandom_range(0, 255), 1'b0);
  endtask

  // Asserts CD mid-cycle (away from CP) and releases it mid-cycle after some edges.
  task automatic apply_reset(input int edges);
    #2;
    CD = 1'b0;
    bus.REQ_VALID = 1'b0;
    bus.CLR_REQ   = 1'b0;
    #1;
    check_reset("rst_async");
    repeat (edges) @(posedge CP);
    @(negedge CP);
    check_reset("rst_held");
    CD = 1'b1;
    model_reset();
    @(posedge CP);
    #1;
    cyc++;
    check("state_after_rst", 32'(bus.dbg_state), 32'(ST_IDLE));
  endtask

  initial begin
    int pend, clr_left, p_addr, p_data;
    bus.REQ_VALID = 1'b0;
    bus.REQ_ADDR  = '0;
    bus.REQ_DATA  = '0;
    bus.CLR_REQ   = 1'b0;
`ifdef GTECH_LATCH_WR_SHADOW_EN
    bus.RD_ADDR   = '0;
    rd_addr_drv   = 2'd1;
`endif
    @(posedge CP);
    #1;
    apply_reset(2);
    idle(2);

    // Basic write to entry 2.
    tick(1'b1, 2, 8'hA5, 1'b0);
    idle(SETUP_CYC + OPEN_CYC + HOLD_CYC + 2);

    // Shadowed write to entry 1, then a clear.
    tick(1'b1, 1, 8'h3C, 1'b0);
    idle(SETUP_CYC + OPEN_CYC + HOLD_CYC + 2);

    // Clear and write requested together: clear first, write taken after DONE.
    tick(1'b1, 0, 8'h5A, 1'b1);
    for (int i = 0; i < 20 && !acc; i++) tick(1'b1, 0, 8'h5A, 1'b0);
    if (!acc) check("wr_after_clr_timeout", 32'(0), 32'(1));
    idle(SETUP_CYC + OPEN_CYC + HOLD_CYC + 2);

    // Out-of-range entry.
    tick(1'b1, 3, 8'h77, 1'b0);
    idle(SETUP_CYC + OPEN_CYC + HOLD_CYC + 2);

    // Reset while the gate is open.
    tick(1'b1, 0, 8'hC3, 1'b0);
    idle(SETUP_CYC);
    check("open_gn", 32'(bus.LD_GN), 32'(3'b110));
    apply_reset(1);
    idle(2);

    // Random traffic with held requests, level clears and occasional resets.
    pend = 0; clr_left = 0; p_addr = 0; p_data = 0;
    for (int k = 0; k < 800; k++) begin
      if (pend == 0 && $urandom_range(0, 2) == 0) begin
        pend   = 1;
        p_addr = $urandom_range(0, 3);
        p_data = $urandom_range(0, 255);
      end
      if (clr_left == 0 && $urandom_range(0, 15) == 0) clr_left = $urandom_range(1, 6);
`ifdef GTECH_LATCH_WR_SHADOW_EN
      rd_addr_drv = AW'($urandom_range(0, 3));
`endif
      tick(pend != 0, p_addr, p_data, clr_left > 0);
      if (acc) pend = 0;
      if (clr_left > 0) clr_left--;
      if ($urandom_range(0, 249) == 0) begin
        apply_reset($urandom_range(0, 2));
        pend = 0;
        clr_left = 0;
      end
    end
    idle(SETUP_CYC + OPEN_CYC + HOLD_CYC + 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
